// File: rtl/xpt_cycle_sequencer.sv
// Machine-cycle sequencer: runs M1 / read / write / internal cycles with T-state
// timing and WAIT stretching, owns the XPT phase counter and the ITABLE opcode latch.
module xpt_cycle_sequencer #(
    parameter int unsigned XPT_W      = 4,
    parameter logic [7:0]  ITABLE_RST = 8'h00
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       cycle_req,
    input  logic             reset_xpt,
    input  logic             bus_wait,
    input  logic [7:0]       data_in,
    output logic [XPT_W-1:0] XPT,
    output logic [XPT_W-1:0] notXPT,
    output logic [7:0]       ITABLE,
    output logic [7:0]       notITABLE,
    output logic             decode_enable,
    output logic             m1,
    output logic             mreq,
    output logic             rd,
    output logic             wr,
    output logic             rfsh,
    output logic             dt_load,
    output logic [7:0]       dt_q,
    output logic [2:0]       tstate,
    output logic             xpt_overflow
);

    typedef enum logic [1:0] {
        CYC_INT = 2'b00,
        CYC_RD  = 2'b01,
        CYC_WR  = 2'b10,
        CYC_M1  = 2'b11
    } cyc_e;

    typedef enum logic [2:0] {
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4,
        TW = 3'd5
    } ts_e;

    typedef struct packed {
        logic m1;
        logic mreq;
        logic rd;
        logic wr;
        logic rfsh;
        logic dec_en;
        logic dt_load;
    } strb_t;

    // Strobe pattern for a given cycle type and T-state; registered from next state.
    function automatic strb_t decode(input cyc_e c, input ts_e t);
        strb_t s;
        s = '0;
        case (c)
            CYC_M1: begin
                case (t)
                    T1, T2, TW: begin s.m1 = 1'b1; s.mreq = 1'b1; s.rd = 1'b1; end
                    T3:         begin s.rfsh = 1'b1; s.mreq = 1'b1; end
                    T4:         begin s.rfsh = 1'b1; s.dec_en = 1'b1; end
                    default:    s = '0;
                endcase
            end
            CYC_RD: begin
                case (t)
                    T1, T2, TW: begin s.mreq = 1'b1; s.rd = 1'b1; end
                    T3:         begin s.dt_load = 1'b1; s.dec_en = 1'b1; end
                    default:    s = '0;
                endcase
            end
            CYC_WR: begin
                case (t)
                    T1:      s.mreq = 1'b1;
                    T2, TW:  begin s.mreq = 1'b1; s.wr = 1'b1; end
                    T3:      begin s.mreq = 1'b1; s.wr = 1'b1; s.dec_en = 1'b1; end
                    default: s = '0;
                endcase
            end
            default: s.dec_en = 1'b1;
        endcase
        return s;
    endfunction

    cyc_e             cyc_q, cyc_d;
    ts_e              ts_q, ts_d;
    logic [XPT_W-1:0] xpt_q, xpt_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       itable_q, itable_d;
    logic [7:0]       dt_reg_q, dt_reg_d;
    strb_t            strb_q;
    logic             last_t;

    // NOTE: every variable gets a default first so no path through this block infers a latch.
    always_comb begin
        cyc_d    = cyc_q;
        ts_d     = ts_q;
        xpt_d    = xpt_q;
        ovf_d    = ovf_q;
        itable_d = itable_q;
        dt_reg_d = dt_reg_q;
        last_t   = (cyc_q == CYC_INT)
                || (cyc_q == CYC_M1 && ts_q == T4)
                || ((cyc_q == CYC_RD || cyc_q == CYC_WR) && ts_q == T3);
        if (last_t) begin
            cyc_d = cyc_e'(cycle_req);
            ts_d  = T1;
            if (cyc_q == CYC_M1 || reset_xpt) begin
                xpt_d = '0;
            end else if (&xpt_q) begin
                ovf_d = 1'b1;
            end else begin
                xpt_d = xpt_q + 1'b1;
            end
        end else begin
            case (ts_q)
                T1:      ts_d = T2;
                T2, TW:  ts_d = bus_wait ? TW : T3;
                T3:      ts_d = T4;
                default: ts_d = T1;
            endcase
            // Data is captured on the edge entering T3; a fetch also restarts the phase
            // count there so the decoder sees phase 0 for the new opcode during T4.
            if (ts_d == T3 && cyc_q == CYC_M1) begin
                itable_d = data_in;
                xpt_d    = '0;
            end
            if (ts_d == T3 && cyc_q == CYC_RD) begin
                dt_reg_d = data_in;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cyc_q    <= CYC_M1;
            ts_q     <= T1;
            xpt_q    <= '0;
            ovf_q    <= 1'b0;
            itable_q <= ITABLE_RST;
            dt_reg_q <= '0;
            strb_q   <= decode(CYC_M1, T1);
        end else begin
            cyc_q    <= cyc_d;
            ts_q     <= ts_d;
            xpt_q    <= xpt_d;
            ovf_q    <= ovf_d;
            itable_q <= itable_d;
            dt_reg_q <= dt_reg_d;
            strb_q   <= decode(cyc_d, ts_d);
        end
    end

    // Strobes are forced low for as long as reset is asserted, not just after the edge.
    assign m1            = strb_q.m1      & ~reset;
    assign mreq          = strb_q.mreq    & ~reset;
    assign rd            = strb_q.rd      & ~reset;
    assign wr            = strb_q.wr      & ~reset;
    assign rfsh          = strb_q.rfsh    & ~reset;
    assign decode_enable = strb_q.dec_en  & ~reset;
    assign dt_load       = strb_q.dt_load & ~reset;

    assign XPT          = xpt_q;
    assign notXPT       = ~xpt_q;
    assign ITABLE       = itable_q;
    assign notITABLE    = ~itable_q;
    assign dt_q         = dt_reg_q;
    assign tstate       = ts_q;
    assign xpt_overflow = ovf_q;

endmodule
